// File: rtl/dmem_responder_pkg.sv
// Shared CPU package: responder FSM state encoding, bus/data widths and the
// address error check used by the data-memory responder.
//   state_t       IDLE / BUSY / RESP encoding of the responder FSM
//   ADDR_W/DATA_W bus widths
//   BYTE_OFS_W    byte-offset bits below the word index
//   CNT_W         latency counter width (LATENCY up to 15)
//   DBG_W         debug word-index width
//   addr_error()  misaligned or out-of-range byte address
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BYTE_OFS_W = 2;
    localparam int CNT_W      = 4;
    localparam int DBG_W      = 3;

    // A word access must be word aligned and fall inside the storage array.
    function automatic logic addr_error(input logic [ADDR_W-1:0] addr,
                                        input int depth_words);
        return (addr[BYTE_OFS_W-1:0] != '0) ||
               (addr >= ADDR_W'(depth_words * 4));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline MEM stage (master) and the
// data-memory responder (slave).
//   req_valid/req_ready     request handshake
//   req_write/addr/wdata    request payload
//   resp_valid              one-cycle response pulse
//   resp_rdata/resp_err     response payload (zero outside resp_valid)
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
//   clk, srst          clock, synchronous active-high reset (clears every word)
//   wr_en/idx/data     synchronous write port
//   rd_en/idx, rd_data synchronous read port (registered, holds between reads)
//   dbg_idx, dbg_data  combinational read of one of the low words
// Every word is cleared by reset, so storage is built from registers.
module dmem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = $clog2(DEPTH_WORDS),
    parameter int DATA_W      = 32,
    parameter int DBG_W       = 3
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DBG_W-1:0]  dbg_idx,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] word_bus [DEPTH_WORDS];
    logic [DATA_W-1:0] rd_data_reg;

    generate
        for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    word_reg <= '0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    word_reg <= wr_data;
                end
            end

            assign word_bus[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= word_bus[rd_idx];
        end
    end

    assign rd_data  = rd_data_reg;
    assign dbg_data = word_bus[IDX_W'(dbg_idx)];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline MEM stage.
//   CLOCK_IN, RESET     clock, synchronous active-high reset
//   bus (slave)         request/response handshake, see dmem_responder_if
//   dbg_addr, dbg_data  combinational debug read of a low storage word
// One request at a time: IDLE accepts, BUSY waits out the latency, RESP
// presents a one-cycle response. The storage access happens on the edge
// that enters RESP.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic              CLOCK_IN,
    input  logic              RESET,
    dmem_responder_if.slave   bus,
    input  logic [DBG_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state_reg,  state_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [ADDR_W-1:0] addr_reg,   addr_next;
    logic              write_reg,  write_next;
    logic [DATA_W-1:0] wdata_reg,  wdata_next;

    logic              enter_resp;
    logic              op_err;
    logic              resp_err_cur;
    logic              wr_en;
    logic              rd_en;
    logic [IDX_W-1:0]  op_idx;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge CLOCK_IN) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            write_reg <= write_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        write_next = write_reg;
        wdata_next = wdata_reg;
        enter_resp = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_next  = bus.req_addr;
                    write_next = bus.req_write;
                    wdata_next = bus.req_wdata;
                    if (LATENCY == 1) begin
                        state_next = ST_RESP;
                        cnt_next   = '0;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_BUSY;
                        cnt_next   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The *_next payload is the operation being completed on the RESP entry
    // edge: the freshly captured request when LATENCY=1, otherwise the held one.
    assign op_err = addr_error(addr_next, DEPTH_WORDS);
    assign op_idx = addr_next[IDX_W+BYTE_OFS_W-1:BYTE_OFS_W];
    assign wr_en  = enter_resp &&  write_next && !op_err;
    assign rd_en  = enter_resp && !write_next && !op_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .DATA_W      (DATA_W),
        .DBG_W       (DBG_W)
    ) u_array (
        .clk      (CLOCK_IN),
        .srst     (RESET),
        .wr_en    (wr_en),
        .wr_idx   (op_idx),
        .wr_data  (wdata_next),
        .rd_en    (rd_en),
        .rd_idx   (op_idx),
        .rd_data  (rd_data),
        .dbg_idx  (dbg_addr),
        .dbg_data (dbg_data)
    );

    // The read register keeps stale data across stores and errors, so the
    // response is gated down to zero for anything but a good load.
    assign resp_err_cur   = addr_error(addr_reg, DEPTH_WORDS);
    assign bus.req_ready  = (state_reg == ST_IDLE);
    assign bus.resp_valid = (state_reg == ST_RESP);
    assign bus.resp_err   = (state_reg == ST_RESP) && resp_err_cur;
    assign bus.resp_rdata = ((state_reg == ST_RESP) && !write_reg && !resp_err_cur)
                            ? rd_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: one DUT with LATENCY=2 and one with LATENCY=1, both
// DEPTH_WORDS=64, checked against a word-array model of the storage.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    logic        clk;
    logic        RESET;
    logic [2:0]  dbg0, dbg1;
    logic [31:0] dbg_data0, dbg_data1;
    int          errors;
    int          checks;
    int          cyc;

    logic [31:0] mem_m [2][DEPTH];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dut (
        .CLOCK_IN (clk),
        .RESET    (RESET),
        .bus      (bus0),
        .dbg_addr (dbg0),
        .dbg_data (dbg_data0)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) dut1 (
        .CLOCK_IN (clk),
        .RESET    (RESET),
        .bus      (bus1),
        .dbg_addr (dbg1),
        .dbg_data (dbg_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cycles after the accept edge until the response shows: the counter
    // spends LATENCY cycles in BUSY, except LATENCY=1 which skips BUSY.
    function automatic int exp_delay(input int lat);
        return (lat == 1) ? 0 : lat;
    endfunction

    function automatic bit model_err(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    // Applies one request to model u and returns the expected resp_rdata.
    function automatic logic [31:0] model_access(input int u, input logic w,
                                                 input logic [31:0] a,
                                                 input logic [31:0] d);
        if (model_err(a)) return 32'h0;
        if (w) begin
            mem_m[u][a / 4] = d;
            return 32'h0;
        end
        return mem_m[u][a / 4];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1;
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < DEPTH; i++) mem_m[u][i] = 32'h0;
    endtask

    // Runs one request on the LATENCY=2 DUT and measures the response.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int delay, output int low, output int pulses,
                         output logic [31:0] rdata, output logic err,
                         output logic [31:0] dbg_at_resp, output bit tmo);
        delay = -1; low = 0; pulses = 0; rdata = '0; err = 1'b0;
        dbg_at_resp = '0; tmo = 1'b1;
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_write = w;
        bus0.req_addr  = a;
        bus0.req_wdata = d;
        for (int k = 0; k < 20 && !bus0.req_ready; k++) @(negedge clk);
        @(posedge clk);
        #1;
        // Scramble the inputs after accept; the captured request must win.
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'($urandom);
        bus0.req_addr  = $urandom;
        bus0.req_wdata = $urandom;
        for (int k = 0; k < 40; k++) begin
            if (bus0.resp_valid) begin
                pulses++;
                if (delay < 0) begin
                    delay = k; rdata = bus0.resp_rdata; err = bus0.resp_err;
                    dbg_at_resp = dbg_data0;
                end
            end
            if (bus0.req_ready) begin
                tmo = 1'b0;
                break;
            end
            low++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus0.req_ready !== 1'b1 || bus1.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b want 1/1", bus0.req_ready, bus1.req_ready);
        end
        checks++;
        if (bus0.resp_valid !== 1'b0 || bus0.resp_err !== 1'b0 || bus0.resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp: valid=%b err=%b rdata=%h want 0/0/0",
                     bus0.resp_valid, bus0.resp_err, bus0.resp_rdata);
        end
        for (int i = 0; i < 8; i++) begin
            dbg0 = 3'(i);
            #1;
            checks++;
            if (dbg_data0 !== 32'h0) begin
                errors++;
                $display("FAIL reset_dbg[%0d]: got %h want 0", i, dbg_data0);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_store_basic();
        int delay, low, pulses; logic [31:0] rdata, dbgv; logic err; bit tmo;
        dbg0 = 3'd2;
        issue(1'b1, 32'h8, 32'hDEADBEEF, delay, low, pulses, rdata, err, dbgv, tmo);
        void'(model_access(0, 1'b1, 32'h8, 32'hDEADBEEF));
        checks++;
        if (tmo || delay !== exp_delay(LAT0) || pulses !== 1) begin
            errors++;
            $display("FAIL store_timing: delay=%0d pulses=%0d tmo=%0b want delay=%0d pulses=1",
                     delay, pulses, tmo, exp_delay(LAT0));
        end
        checks++;
        if (err !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL store_resp: err=%b rdata=%h want 0/0", err, rdata);
        end
        checks++;
        if (dbgv !== 32'hDEADBEEF || dbg_data0 !== mem_m[0][2]) begin
            errors++;
            $display("FAIL store_dbg: at_resp=%h now=%h want %h", dbgv, dbg_data0, mem_m[0][2]);
        end
        $display("store addr=0x8 data=deadbeef: delay=%0d err=%b", delay, err);
    endtask

    task automatic test_load_basic();
        int delay, low, pulses; logic [31:0] rdata, dbgv; logic err; bit tmo;
        logic [31:0] exp;
        exp = model_access(0, 1'b0, 32'h8, 32'h0);
        issue(1'b0, 32'h8, 32'h0, delay, low, pulses, rdata, err, dbgv, tmo);
        checks++;
        if (tmo || delay !== exp_delay(LAT0) || low !== exp_delay(LAT0) + 1) begin
            errors++;
            $display("FAIL load_timing: delay=%0d ready_low=%0d want %0d/%0d",
                     delay, low, exp_delay(LAT0), exp_delay(LAT0) + 1);
        end
        checks++;
        if (rdata !== exp || err !== 1'b0) begin
            errors++;
            $display("FAIL load_data: rdata=%h err=%b want %h/0", rdata, err, exp);
        end
        $display("load addr=0x8: rdata=%h ready_low=%0d", rdata, low);
    endtask

    task automatic test_misaligned();
        int delay, low, pulses; logic [31:0] rdata, dbgv; logic err; bit tmo;
        logic [31:0] exp;
        dbg0 = 3'd1;
        issue(1'b1, 32'h4, 32'hA5A50004, delay, low, pulses, rdata, err, dbgv, tmo);
        void'(model_access(0, 1'b1, 32'h4, 32'hA5A50004));
        issue(1'b1, 32'h6, 32'h00001234, delay, low, pulses, rdata, err, dbgv, tmo);
        void'(model_access(0, 1'b1, 32'h6, 32'h00001234));
        checks++;
        if (tmo || err !== 1'b1 || rdata !== 32'h0 || pulses !== 1) begin
            errors++;
            $display("FAIL misaligned_store: err=%b rdata=%h pulses=%0d want 1/0/1", err, rdata, pulses);
        end
        checks++;
        if (dbg_data0 !== mem_m[0][1]) begin
            errors++;
            $display("FAIL misaligned_storage: word1=%h want %h", dbg_data0, mem_m[0][1]);
        end
        exp = model_access(0, 1'b0, 32'h4, 32'h0);
        issue(1'b0, 32'h4, 32'h0, delay, low, pulses, rdata, err, dbgv, tmo);
        checks++;
        if (rdata !== exp || err !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_reload: rdata=%h err=%b want %h/0", rdata, err, exp);
        end
        $display("store addr=0x6 (misaligned): err=1 expected, reload 0x4 rdata=%h", rdata);
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [5];
        logic        wr    [5];
        int delay, low, pulses; logic [31:0] rdata, dbgv; logic err; bit tmo;
        logic [31:0] exp;
        addrs = '{32'h100, 32'hFC, 32'h104, 32'hFFFFFFFC, 32'h100};
        wr    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            exp = model_access(0, wr[i], addrs[i], 32'hC0FFEE00 + 32'(i));
            issue(wr[i], addrs[i], 32'hC0FFEE00 + 32'(i), delay, low, pulses, rdata, err, dbgv, tmo);
            checks++;
            if (tmo || err !== model_err(addrs[i]) || rdata !== exp) begin
                errors++;
                $display("FAIL range[%0d] addr=%h: err=%b rdata=%h want %b/%h",
                         i, addrs[i], err, rdata, model_err(addrs[i]), exp);
            end
            $display("range write=%b addr=%h: err=%b rdata=%h", wr[i], addrs[i], err, rdata);
        end
    endtask

    task automatic test_random();
        int delay, low, pulses; logic [31:0] rdata, dbgv; logic err; bit tmo;
        logic [31:0] a, d, exp; logic w;
        for (int n = 0; n < 24; n++) begin
            w = 1'($urandom);
            a = 32'($urandom_range(0, 71)) * 4;
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            if (n < 8) a = 32'($urandom_range(0, 7)) * 4;
            d = $urandom;
            dbg0 = 3'($urandom_range(0, 7));
            exp = model_access(0, w, a, d);
            issue(w, a, d, delay, low, pulses, rdata, err, dbgv, tmo);
            checks++;
            if (tmo || delay !== exp_delay(LAT0) || low !== exp_delay(LAT0) + 1 || pulses !== 1
                || rdata !== exp || err !== model_err(a) || dbg_data0 !== mem_m[0][dbg0]) begin
                errors++;
                $display("FAIL random[%0d] w=%b addr=%h: delay=%0d low=%0d rdata=%h err=%b dbg=%h want %0d/%0d/%h/%b/%h",
                         n, w, a, delay, low, rdata, err, dbg_data0,
                         exp_delay(LAT0), exp_delay(LAT0) + 1, exp, model_err(a), mem_m[0][dbg0]);
            end
            $display("random[%0d] w=%b addr=%h data=%h: rdata=%h err=%b", n, w, a, d, rdata, err);
        end
    endtask

    task automatic test_reset_midop();
        int pulses;
        dbg0 = 3'd3;
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1;
        bus0.req_addr = 32'hC; bus0.req_wdata = 32'h600DF00D;
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        checks++;
        if (bus0.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_busy: ready=%b want 0", bus0.req_ready);
        end
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[0][i] = 32'h0;
        checks++;
        if (bus0.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_ready: ready=%b want 1", bus0.req_ready);
        end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus0.resp_valid) pulses++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulses !== 0 || dbg_data0 !== mem_m[0][3]) begin
            errors++;
            $display("FAIL midop_abort: pulses=%0d word3=%h want 0/%h", pulses, dbg_data0, mem_m[0][3]);
        end
        // Reset wins over an accept in the same cycle.
        @(negedge clk);
        RESET = 1'b1; bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h10;
        @(negedge clk);
        RESET = 1'b0; bus0.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus0.req_ready !== 1'b1 || bus0.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: ready=%b valid=%b want 1/0", bus0.req_ready, bus0.resp_valid);
        end
        $display("reset during busy: pulses=%0d word3=%h", pulses, dbg_data0);
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < DEPTH; i++) mem_m[u][i] = 32'h0;
    endtask

    task automatic test_back_to_back();
        int acc, prev_acc, waited;
        logic [31:0] a, d, exp; logic w;
        prev_acc = 0;
        @(negedge clk);
        for (int n = 0; n < 12; n++) begin
            w = (n < 4) ? 1'b1 : 1'($urandom);
            a = 32'($urandom_range(0, 7)) * 4;
            if (n == 9) a = 32'h102;
            d = $urandom;
            bus1.req_valid = 1'b1; bus1.req_write = w; bus1.req_addr = a; bus1.req_wdata = d;
            exp = model_access(1, w, a, d);
            waited = 0;
            while (!bus1.req_ready && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            if (!bus1.req_ready) begin
                checks++; errors++;
                $display("FAIL b2b_ready[%0d]: ready never rose", n);
                break;
            end
            @(posedge clk);
            #1;
            acc = cyc;
            checks++;
            if (bus1.resp_valid !== 1'b1 || bus1.resp_rdata !== exp || bus1.resp_err !== model_err(a)) begin
                errors++;
                $display("FAIL b2b_resp[%0d] w=%b addr=%h: valid=%b rdata=%h err=%b want 1/%h/%b",
                         n, w, a, bus1.resp_valid, bus1.resp_rdata, bus1.resp_err, exp, model_err(a));
            end
            if (n > 0) begin
                checks++;
                if (acc - prev_acc !== 2) begin
                    errors++;
                    $display("FAIL b2b_interval[%0d]: got %0d want 2", n, acc - prev_acc);
                end
            end
            $display("b2b[%0d] w=%b addr=%h: rdata=%h err=%b interval=%0d",
                     n, w, a, bus1.resp_rdata, bus1.resp_err, acc - prev_acc);
            prev_acc = acc;
            @(negedge clk);
        end
        bus1.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        errors = 0; checks = 0;
        RESET = 1'b1;
        dbg0 = '0; dbg1 = '0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        test_reset();
        test_store_basic();
        test_load_basic();
        test_misaligned();
        test_out_of_range();
        test_random();
        test_reset_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
